axi_mgr_wr_ch: RTL and testbench
================================

AXI_MGR_WR_CH -- requirements
Module: axi_mgr_wr_ch

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning the address width.
REQ-002 SHALL have parameter DATA_W, default 64, meaning the data width (multiple of 8).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 256, meaning the B-wait limit in cycles (used only with AXI_WR_TIMEOUT_EN).
REQ-004 SHALL have the following ports; clock is ACLK, reset is ARESETn, one clock, reset synchronous and active-low.
  ACLK  in  1  clock
  ARESETn  in  1  sync active-low reset
  tx_start  in  1  request one write; sampled in IDLE
  tx_addr  in  ADDR_W  write address; captured with tx_start
  tx_data  in  DATA_W  write data; captured with tx_start
  busy  out  1  transaction in flight
  done  out  1  one-cycle completion pulse
  bresp  out  2  response of last completed write
  AWADDR  out  ADDR_W  write address channel
  AWVALID  out  1  AW valid
  AWREADY  in  1  AW ready
  WDATA  out  DATA_W  write data channel
  WSTRB  out  DATA_W/8  byte strobes, all ones
  WLAST  out  1  constant 1 (single beat)
  WVALID  out  1  W valid
  WREADY  in  1  W ready
  BRESP  in  2  write response
  BVALID  in  1  B valid
  BREADY  out  1  B ready

Function
REQ-005 SHALL implement FSM states IDLE, ADDR_DATA, WAIT_B.
REQ-006 SHALL, in IDLE with tx_start=1 at a rising edge, capture tx_addr/tx_data and enter ADDR_DATA; AWVALID=WVALID=busy=1 from the next cycle.
REQ-007 SHALL ignore tx_start outside IDLE.
REQ-008 SHALL treat AW and W independently: each VALID held with stable payload until VALID&READY at an edge, then deasserted next cycle; flags aw_done/w_done record completion.
REQ-009 SHALL never drive AWVALID, WVALID or BREADY combinationally from any READY/VALID input (registered outputs).
REQ-010 SHALL accept AW and W handshakes in either order or in the same cycle.
REQ-011 SHALL enter WAIT_B and assert BREADY the cycle after both aw_done and w_done are set; BREADY=0 in all other states.
REQ-012 SHALL ignore BVALID asserted before WAIT_B (no capture, BREADY stays 0).
REQ-013 SHALL, on BVALID&BREADY, register BRESP into bresp, pulse done for exactly the next cycle, and return to IDLE with busy=0.
REQ-014 SHALL accept tx_start in the cycle done=1 (back-to-back writes).
REQ-015 SHALL hold bresp until the next completion.

Reset
REQ-016 SHALL, on ARESETn=0 at a rising edge, force IDLE and clear AWVALID, WVALID, BREADY, busy, done, bresp, AWADDR, WDATA and internal flags to 0, including mid-transaction.

Configuration
REQ-017 SHALL, with AXI_WR_TIMEOUT_EN defined, count cycles in WAIT_B; on reaching TIMEOUT_CYC without BVALID, set bresp=2'b10 (SLVERR), pulse done, deassert BREADY, return to IDLE; counter clears on entering WAIT_B.
REQ-018 SHALL, without AXI_WR_TIMEOUT_EN, contain no counter and wait in WAIT_B indefinitely.

Structure
REQ-019 SHALL take resp_t (OKAY=00, EXOKAY=01, SLVERR=10, DECERR=11) and the FSM state enum from shared package axi_pkg.
REQ-020 SHALL be a single flat module; no sub-module.

Verification
REQ-021 Reset mid-ADDR_DATA -> next cycle AWVALID=WVALID=busy=0, state IDLE.
REQ-022 tx_start, addr 0x1000, data 0xDEAD_BEEF_0000_0001, AWREADY=WREADY=1, BVALID=1 BRESP=00 -> AW/W handshake cycle 1, BREADY cycle 2, done=1 cycle 3, bresp=00.
REQ-023 WREADY at cycle 1, AWREADY delayed to cycle 5 -> WVALID drops cycle 2, AWADDR stable 0x1000 through cycle 5, BREADY cycle 6.
REQ-024 BVALID=1 BRESP=11 held from cycle 0 -> no BREADY before both handshakes; final bresp=11.
REQ-025 tx_start held high continuously, 3 writes -> each done pulse followed by AWVALID the next cycle; tx_start during busy ignored.
REQ-026 AXI_WR_TIMEOUT_EN, TIMEOUT_CYC=8, BVALID never asserted -> done after 8 WAIT_B cycles, bresp=10, state IDLE.

Source files
------------

// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_pkg
//  Description : Shared AXI write-channel types: response codes and the
//                write-manager FSM state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package axi_pkg;

    // AXI write response codes.
    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    // Write-manager FSM states.
    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        ADDR_DATA = 2'b01,
        WAIT_B    = 2'b10
    } wr_state_t;

endpackage : axi_pkg
`default_nettype wire

// File: rtl/axi_mgr_wr_ch.sv
`default_nettype none
// ============================================================================
//  Module      : axi_mgr_wr_ch
//  Description : Single-beat AXI write manager. One tx_start in IDLE issues
//                one AW + one W transfer (independent handshakes, any order),
//                then waits for the B response and reports it on bresp with
//                a one-cycle done pulse. All channel outputs are registered.
//  Optional    : define AXI_WR_TIMEOUT_EN to abort WAIT_B after TIMEOUT_CYC
//                cycles with bresp = SLVERR.
//  Ports       : ACLK, ARESETn (sync, active-low)
//                tx_start/tx_addr/tx_data  - request side
//                busy/done/bresp           - status side
//                AW*/W*/B*                 - AXI write channels
//  Revision    : 1.0  initial release
// ============================================================================
module axi_mgr_wr_ch
    import axi_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 64,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  tx_start,
    input  logic [ADDR_W-1:0]     tx_addr,
    input  logic [DATA_W-1:0]     tx_data,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            bresp,
    output logic [ADDR_W-1:0]     AWADDR,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [DATA_W-1:0]     WDATA,
    output logic [DATA_W/8-1:0]   WSTRB,
    output logic                  WLAST,
    output logic                  WVALID,
    input  logic                  WREADY,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY
);

    wr_state_t          r_state;
    logic [ADDR_W-1:0]  r_awaddr;
    logic [DATA_W-1:0]  r_wdata;
    logic               r_awvalid;
    logic               r_wvalid;
    logic               r_bready;
    logic               r_busy;
    logic               r_done;
    resp_t              r_bresp;
    logic               r_aw_done;
    logic               r_w_done;

    // Completion status including a handshake happening at this edge; lets
    // the FSM move to WAIT_B in the same edge the second handshake lands.
    logic w_aw_done_nxt;
    logic w_w_done_nxt;
    assign w_aw_done_nxt = r_aw_done | (r_awvalid & AWREADY);
    assign w_w_done_nxt  = r_w_done  | (r_wvalid  & WREADY);

`ifdef AXI_WR_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [c_CNT_W-1:0] r_to_cnt;
`else
    // Timeout limit has no function in this build.
    logic w_unused_timeout_cyc;
    assign w_unused_timeout_cyc = |TIMEOUT_CYC;
`endif

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_state   <= IDLE;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_bresp   <= OKAY;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
`ifdef AXI_WR_TIMEOUT_EN
            r_to_cnt  <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (tx_start) begin
                        r_awaddr  <= tx_addr;
                        r_wdata   <= tx_data;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_busy    <= 1'b1;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_state   <= ADDR_DATA;
                    end
                end
                ADDR_DATA: begin
                    if (r_awvalid && AWREADY) r_awvalid <= 1'b0;
                    if (r_wvalid && WREADY)   r_wvalid  <= 1'b0;
                    r_aw_done <= w_aw_done_nxt;
                    r_w_done  <= w_w_done_nxt;
                    if (w_aw_done_nxt && w_w_done_nxt) begin
                        r_bready <= 1'b1;
                        r_state  <= WAIT_B;
`ifdef AXI_WR_TIMEOUT_EN
                        r_to_cnt <= '0;
`endif
                    end
                end
                WAIT_B: begin
                    if (BVALID) begin
                        r_bresp   <= resp_t'(BRESP);
                        r_done    <= 1'b1;
                        r_bready  <= 1'b0;
                        r_busy    <= 1'b0;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_state   <= IDLE;
                    end
`ifdef AXI_WR_TIMEOUT_EN
                    // Final WAIT_B cycle is the one where the count shows
                    // TIMEOUT_CYC-1, giving exactly TIMEOUT_CYC wait cycles.
                    else if (r_to_cnt == c_CNT_W'(TIMEOUT_CYC - 1)) begin
                        r_bresp   <= SLVERR;
                        r_done    <= 1'b1;
                        r_bready  <= 1'b0;
                        r_busy    <= 1'b0;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_state   <= IDLE;
                    end else begin
                        r_to_cnt  <= r_to_cnt + c_CNT_W'(1);
                    end
`endif
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign bresp   = r_bresp;
    assign AWADDR  = r_awaddr;
    assign AWVALID = r_awvalid;
    assign WDATA   = r_wdata;
    assign WSTRB   = '1;
    assign WLAST   = 1'b1;
    assign WVALID  = r_wvalid;
    assign BREADY  = r_bready;

endmodule : axi_mgr_wr_ch
`default_nettype wire

// File: tb/tb_axi_mgr_wr_ch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_mgr_wr_ch
//  Description : Directed self-checking bench for axi_mgr_wr_ch. Cycle 0 is
//                the cycle in which tx_start is presented; inputs are driven
//                and outputs sampled 1 time unit after each rising edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_axi_mgr_wr_ch;

    logic          ACLK = 1'b0;
    logic          ARESETn;
    logic          tx_start;
    logic [31:0]   tx_addr;
    logic [63:0]   tx_data;
    logic          busy;
    logic          done;
    logic [1:0]    bresp;
    logic [31:0]   AWADDR;
    logic          AWVALID;
    logic          AWREADY;
    logic [63:0]   WDATA;
    logic [7:0]    WSTRB;
    logic          WLAST;
    logic          WVALID;
    logic          WREADY;
    logic [1:0]    BRESP;
    logic          BVALID;
    logic          BREADY;

    int n_checks = 0;
    int n_errors = 0;

    always #5 ACLK = ~ACLK;

    axi_mgr_wr_ch #(
        .ADDR_W      (32),
        .DATA_W      (64),
        .TIMEOUT_CYC (8)
    ) dut (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .tx_start (tx_start),
        .tx_addr  (tx_addr),
        .tx_data  (tx_data),
        .busy     (busy),
        .done     (done),
        .bresp    (bresp),
        .AWADDR   (AWADDR),
        .AWVALID  (AWVALID),
        .AWREADY  (AWREADY),
        .WDATA    (WDATA),
        .WSTRB    (WSTRB),
        .WLAST    (WLAST),
        .WVALID   (WVALID),
        .WREADY   (WREADY),
        .BRESP    (BRESP),
        .BVALID   (BVALID),
        .BREADY   (BREADY)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic idle_inputs();
        tx_start = 1'b0;
        AWREADY  = 1'b0;
        WREADY   = 1'b0;
        BVALID   = 1'b0;
        BRESP    = 2'b00;
    endtask

    initial begin
        ARESETn = 1'b0;
        tx_addr = '0;
        tx_data = '0;
        idle_inputs();
        tick();
        tick();

        // ---------------- reset state ----------------
        check("rst_awvalid", AWVALID, 0);
        check("rst_wvalid",  WVALID,  0);
        check("rst_bready",  BREADY,  0);
        check("rst_busy",    busy,    0);
        check("rst_done",    done,    0);
        check("rst_bresp",   bresp,   0);
        check("rst_awaddr",  AWADDR,  0);
        check("rst_wdata",   WDATA,   0);
        check("wstrb_ones",  WSTRB,   8'hFF);
        check("wlast_one",   WLAST,   1);
        ARESETn = 1'b1;
        tick();

        // ---------------- reset mid-ADDR_DATA ----------------
        tx_start = 1'b1; tx_addr = 32'h0000_0500; tx_data = 64'h1111_2222_3333_4444;
        tick();                                   // cycle 1
        tx_start = 1'b0;
        check("mid_awvalid_pre", AWVALID, 1);
        check("mid_busy_pre",    busy,    1);
        ARESETn = 1'b0;
        tick();                                   // cycle 2
        check("mid_awvalid", AWVALID, 0);
        check("mid_wvalid",  WVALID,  0);
        check("mid_busy",    busy,    0);
        check("mid_awaddr",  AWADDR,  0);
        check("mid_wdata",   WDATA,   0);
        ARESETn = 1'b1;
        tick();
        check("mid_idle_awvalid", AWVALID, 0);

        // ---------------- basic write, all ready ----------------
        tx_start = 1'b1; tx_addr = 32'h0000_1000; tx_data = 64'hDEAD_BEEF_0000_0001;
        AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b1; BRESP = 2'b00;
        tick();                                   // cycle 1
        tx_start = 1'b0;
        check("b1_awvalid", AWVALID, 1);
        check("b1_wvalid",  WVALID,  1);
        check("b1_busy",    busy,    1);
        check("b1_awaddr",  AWADDR,  32'h0000_1000);
        check("b1_wdata",   WDATA,   64'hDEAD_BEEF_0000_0001);
        check("b1_bready",  BREADY,  0);
        tick();                                   // cycle 2
        check("b2_awvalid", AWVALID, 0);
        check("b2_wvalid",  WVALID,  0);
        check("b2_bready",  BREADY,  1);
        check("b2_done",    done,    0);
        tick();                                   // cycle 3
        check("b3_done",   done,   1);
        check("b3_bresp",  bresp,  2'b00);
        check("b3_bready", BREADY, 0);
        check("b3_busy",   busy,   0);
        idle_inputs();
        tick();                                   // cycle 4
        check("b4_done", done, 0);

        // ---------------- W first, AW delayed to cycle 5 ----------------
        tx_start = 1'b1; tx_addr = 32'h0000_1000; tx_data = 64'h0123_4567_89AB_CDEF;
        tick();                                   // cycle 1
        tx_start = 1'b0;
        WREADY = 1'b1;
        for (int c = 2; c <= 5; c++) begin
            tick();                               // cycles 2..5
            WREADY = 1'b0;
            if (c == 3) begin
                tx_start = 1'b1;                  // must be ignored while busy
                tx_addr  = 32'h0000_9999;
            end else begin
                tx_start = 1'b0;
            end
            check("d_wvalid",  WVALID,  0);
            check("d_awvalid", AWVALID, 1);
            check("d_awaddr",  AWADDR,  32'h0000_1000);
            check("d_bready",  BREADY,  0);
            if (c == 5) AWREADY = 1'b1;
        end
        tick();                                   // cycle 6
        AWREADY = 1'b0;
        check("d6_awvalid", AWVALID, 0);
        check("d6_bready",  BREADY,  1);
        BVALID = 1'b1; BRESP = 2'b01;
        tick();                                   // cycle 7
        check("d7_done",  done,  1);
        check("d7_bresp", bresp, 2'b01);
        idle_inputs();
        tick();

        // ---------------- early BVALID is ignored ----------------
        tx_start = 1'b1; tx_addr = 32'h0000_2000; tx_data = 64'hA5A5_A5A5_5A5A_5A5A;
        BVALID = 1'b1; BRESP = 2'b11;
        tick();                                   // cycle 1
        tx_start = 1'b0;
        check("e1_bready", BREADY, 0);
        check("e1_done",   done,   0);
        WREADY = 1'b1;
        tick();                                   // cycle 2
        check("e2_bready", BREADY, 0);
        WREADY = 1'b0;
        tick();                                   // cycle 3
        check("e3_wvalid", WVALID, 0);
        check("e3_bready", BREADY, 0);
        check("e3_bresp_hold", bresp, 2'b01);
        AWREADY = 1'b1;
        tick();                                   // cycle 4
        AWREADY = 1'b0;
        check("e4_bready", BREADY, 1);
        tick();                                   // cycle 5
        check("e5_done",  done,  1);
        check("e5_bresp", bresp, 2'b11);
        idle_inputs();
        tick();

        // ---------------- back-to-back with tx_start held ----------------
        tx_start = 1'b1; AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b1; BRESP = 2'b00;
        tx_addr = 32'h0000_3000;
        for (int k = 0; k < 3; k++) begin
            tick();                               // write k, cycle 1
            check("bb_awvalid", AWVALID, 1);
            check("bb_awaddr",  AWADDR,  32'h0000_3000 + 32'(k * 16));
            check("bb_done0",   done,    0);
            tx_addr = 32'h0000_3000 + 32'((k + 1) * 16);
            tick();                               // cycle 2
            check("bb_bready",  BREADY,  1);
            check("bb_awvalid_busy", AWVALID, 0);
            tick();                               // cycle 3 = next cycle 0
            check("bb_done",    done,    1);
            check("bb_bresp",   bresp,   2'b00);
            if (k == 2) tx_start = 1'b0;
        end
        tick();
        check("bb_end_busy",    busy,    0);
        check("bb_end_awvalid", AWVALID, 0);
        idle_inputs();
        tick();

        // ---------------- B never arrives ----------------
        tx_start = 1'b1; tx_addr = 32'h0000_4000; AWREADY = 1'b1; WREADY = 1'b1;
        tick();                                   // cycle 1
        tx_start = 1'b0;
`ifdef AXI_WR_TIMEOUT_EN
        for (int c = 2; c <= 9; c++) begin
            tick();                               // WAIT_B cycles 2..9
            check("to_bready", BREADY, 1);
            check("to_done",   done,   0);
        end
        tick();                                   // cycle 10
        check("to_done_pulse", done,   1);
        check("to_bresp",      bresp,  2'b10);
        check("to_bready_off", BREADY, 0);
        check("to_busy",       busy,   0);
        tick();
        check("to_done_end",   done,   0);
`else
        for (int c = 2; c <= 21; c++) begin
            tick();
            check("nt_bready", BREADY, 1);
            check("nt_done",   done,   0);
        end
        BVALID = 1'b1; BRESP = 2'b00;
        tick();
        check("nt_done_pulse", done,  1);
        check("nt_bresp",      bresp, 2'b00);
        check("nt_busy",       busy,  0);
`endif
        idle_inputs();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_axi_mgr_wr_ch
`default_nettype wire
